significand_norm_round: RTL
===========================

SIGNIFICAND_NORM_ROUND -- requirements
Module: significand_norm_round

Interface
REQ-001 Parameter W, default 24, significand width including hidden bit; product input is 2W bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 Valid_i  input  1  upstream product valid.
REQ-005 Ready_o  output  1  block can accept a product this cycle.
REQ-006 Data_P_i  input  2W  unsigned product of two normalized significands (upstream multiplier output).
REQ-007 Sign_i  input  1  sign of the result, used by directed rounding modes.
REQ-008 Rmode_i  input  2  rounding mode: 00 nearest-even, 01 toward zero, 10 toward +inf, 11 toward -inf; sampled with Data_P_i.
REQ-009 Valid_o  output  1  result valid.
REQ-010 Ready_i  input  1  downstream accepts result.
REQ-011 Data_M_o  output  W  normalized, rounded significand (MSB = hidden bit).
REQ-012 Exp_inc_o  output  2  exponent increment, range 0..2.
REQ-013 Inexact_o  output  1  discarded bits nonzero.
REQ-014 Zero_o  output  1  product was zero.

Function
REQ-015 Two-stage elastic pipeline: S1 normalizes and extracts guard/sticky; S2 rounds and post-normalizes; both stages registered.
REQ-016 Latency: 2 cycles from handshake (Valid_i & Ready_o) to Valid_o with no back-pressure; throughput 1 per cycle.
REQ-017 Input transfer when Valid_i & Ready_o; output transfer when Valid_o & Ready_i.
REQ-018 Stage advances when next stage empty or next stage transfers the same cycle; Ready_o = ~S1_valid | S1 advancing (combinational).
REQ-019 Valid_o and Data_M_o/Exp_inc_o/Inexact_o/Zero_o stay stable while Valid_o & ~Ready_i.
REQ-020 Up to 2 items held; none dropped or duplicated; order preserved.
REQ-021 Normalize, P[2W-1]=1: M=P[2W-1:W], G=P[W-1], S=|P[W-2:0], shift=1.
REQ-022 Normalize, P[2W-1]=0: M=P[2W-2:W-1], G=P[W-2], S=|P[W-3:0], shift=0.
REQ-023 Round-up: RNE G&(S|M[0]); RTZ 0; +inf (G|S)&~Sign; -inf (G|S)&Sign.
REQ-024 If round-up and M all ones: Data_M_o = 1 followed by W-1 zeros, carry=1; else Data_M_o = M+up, carry=0.
REQ-025 Exp_inc_o = shift + carry; Inexact_o = G|S.
REQ-026 Data_P_i = 0: Data_M_o=0, Exp_inc_o=0, Inexact_o=0, Zero_o=1, all modes; otherwise Zero_o=0.
REQ-027 Data_P_i with P[2W-1:2W-2]=00 and nonzero is out of contract; output is the REQ-022 result, no flag.
REQ-028 Accept and drain in same cycle with pipeline full are both honored; occupancy unchanged.

Reset
REQ-029 rst high at a clock edge clears both stage valids; next cycle Valid_o=0, Data_M_o=0, Exp_inc_o=0, Inexact_o=0, Zero_o=0, Ready_o=1.
REQ-030 Reset mid-operation discards in-flight items; no result from them appears after reset.
REQ-031 While rst high, Ready_o=0 and inputs are ignored.

Verification (W=4)
REQ-032 P=8'h40, RNE -> 2 cycles later M=4'b1000, Exp_inc=0, Inexact=0, Zero=0.
REQ-033 P=8'hE1 (15*15), RNE -> M=4'b1110, Exp_inc=1, Inexact=1; P=8'hA9 (13*13), RNE -> M=4'b1011, Exp_inc=1, Inexact=1.
REQ-034 P=8'h7C, RNE -> M=4'b1000, Exp_inc=1, Inexact=1; same P, RTZ -> M=4'b1111, Exp_inc=0; same P, mode 11, Sign=0 -> M=4'b1111.
REQ-035 Ready_i=0 for 4 cycles, Valid_i=1 with P=8'h40,8'hE1,8'hA9 -> Ready_o falls after 2 accepts; on Ready_i=1, results emerge in order, third accepted, none lost.
REQ-036 P=0, any mode -> Zero=1, M=0, Exp_inc=0, Inexact=0; rst pulsed with 2 items in flight -> Valid_o=0 next cycle, no stale output.

Source files
------------

// File: rtl/significand_norm_round.sv
// -----------------------------------------------------------------------------
// significand_norm_round
//
// Normalizes and rounds the 2W-bit product of two normalized W-bit significands
// (hidden bit included) back to a W-bit significand. Two-stage elastic
// pipeline with valid/ready handshakes on both sides:
//   S1: picks the normalization window from the product MSB and extracts the
//       kept significand M, guard bit G and sticky bit S.
//   S2: applies the selected rounding mode, handles the all-ones carry-out
//       (post-normalization) and produces the exponent increment and flags.
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous, active-high reset
//   Valid_i    upstream product valid
//   Ready_o    block can accept a product this cycle
//   Data_P_i   unsigned 2W-bit product
//   Sign_i     result sign, used by the directed rounding modes
//   Rmode_i    00 nearest-even, 01 toward zero, 10 toward +inf, 11 toward -inf
//   Valid_o    result valid
//   Ready_i    downstream accepts the result
//   Data_M_o   normalized, rounded significand (MSB = hidden bit)
//   Exp_inc_o  exponent increment, 0..2
//   Inexact_o  discarded bits were nonzero
//   Zero_o     product was zero
//
// W must be at least 3 so that both sticky windows are non-empty.
// -----------------------------------------------------------------------------
module significand_norm_round #(
    parameter int W = 24
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           Valid_i,
    output logic           Ready_o,
    input  logic [2*W-1:0] Data_P_i,
    input  logic           Sign_i,
    input  logic [1:0]     Rmode_i,
    output logic           Valid_o,
    input  logic           Ready_i,
    output logic [W-1:0]   Data_M_o,
    output logic [1:0]     Exp_inc_o,
    output logic           Inexact_o,
    output logic           Zero_o
);

    localparam int PW = 2 * W;

    localparam logic [1:0] RM_RNE  = 2'b00;
    localparam logic [1:0] RM_RTZ  = 2'b01;
    localparam logic [1:0] RM_RPOS = 2'b10;
    localparam logic [1:0] RM_RNEG = 2'b11;

    // ------------------------------------------------------------------------
    // Stage 1 combinational: normalization window and guard/sticky extraction
    // ------------------------------------------------------------------------
    // Running OR of the low product bits: low_or[k] = |Data_P_i[k:0].
    // Both sticky windows are prefixes of this chain, so one chain serves both
    // the shifted (k = W-2) and unshifted (k = W-3) cases.
    logic [W-2:0] low_or;

    genvar gi;
    generate
        for (gi = 0; gi < W - 1; gi++) begin : g_sticky
            if (gi == 0) begin : g_first
                assign low_or[gi] = Data_P_i[gi];
            end else begin : g_chain
                assign low_or[gi] = low_or[gi-1] | Data_P_i[gi];
            end
        end
    endgenerate

    logic         n1_shift;
    logic [W-1:0] n1_m;
    logic         n1_g;
    logic         n1_s;
    logic         n1_zero;

    always_comb begin
        n1_shift = Data_P_i[PW-1];
        n1_zero  = ~|Data_P_i;
        if (n1_shift) begin
            n1_m = Data_P_i[PW-1:W];
            n1_g = Data_P_i[W-1];
            n1_s = low_or[W-2];
        end else begin
            // Also covers products with the top two bits clear; such inputs
            // are outside the multiplier contract and simply take this path.
            n1_m = Data_P_i[PW-2:W-1];
            n1_g = Data_P_i[W-2];
            n1_s = low_or[W-3];
        end
    end

    // ------------------------------------------------------------------------
    // Stage 1 registers
    // ------------------------------------------------------------------------
    logic         s1_valid_q, s1_valid_d;
    logic [W-1:0] s1_m_q,     s1_m_d;
    logic         s1_g_q,     s1_g_d;
    logic         s1_s_q,     s1_s_d;
    logic         s1_shift_q, s1_shift_d;
    logic         s1_zero_q,  s1_zero_d;
    logic         s1_sign_q,  s1_sign_d;
    logic [1:0]   s1_rmode_q, s1_rmode_d;

    // ------------------------------------------------------------------------
    // Stage 2 combinational: rounding and post-normalization
    // ------------------------------------------------------------------------
    logic         r2_up;
    logic         r2_all_ones;
    logic         r2_carry;
    logic [W-1:0] r2_m;
    logic [1:0]   r2_exp_inc;
    logic         r2_inexact;

    always_comb begin
        r2_inexact = s1_g_q | s1_s_q;

        unique case (s1_rmode_q)
            RM_RNE:  r2_up = s1_g_q & (s1_s_q | s1_m_q[0]);
            RM_RTZ:  r2_up = 1'b0;
            RM_RPOS: r2_up = r2_inexact & ~s1_sign_q;
            RM_RNEG: r2_up = r2_inexact &  s1_sign_q;
            default: r2_up = 1'b0;
        endcase

        r2_all_ones = &s1_m_q;

        // Rounding an all-ones significand overflows into the next binade:
        // the significand becomes 1.000... and the exponent gains one more.
        if (r2_up && r2_all_ones) begin
            r2_m     = {1'b1, {(W-1){1'b0}}};
            r2_carry = 1'b1;
        end else begin
            r2_m     = s1_m_q + {{(W-1){1'b0}}, r2_up};
            r2_carry = 1'b0;
        end

        r2_exp_inc = {1'b0, s1_shift_q} + {1'b0, r2_carry};
    end

    // ------------------------------------------------------------------------
    // Stage 2 (output) registers
    // ------------------------------------------------------------------------
    logic         s2_valid_q,   s2_valid_d;
    logic [W-1:0] s2_m_q,       s2_m_d;
    logic [1:0]   s2_exp_inc_q, s2_exp_inc_d;
    logic         s2_inexact_q, s2_inexact_d;
    logic         s2_zero_q,    s2_zero_d;

    // ------------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------------
    // S2 can load when it is empty or its current item leaves this cycle.
    // S1 can load when it is empty or its current item moves into S2.
    logic s2_take;
    logic s1_ready;
    logic accept;

    always_comb begin
        s2_take  = ~s2_valid_q | Ready_i;
        s1_ready = ~s1_valid_q | s2_take;
        Ready_o  = ~rst & s1_ready;
        accept   = Valid_i & Ready_o;
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_m_d       = s1_m_q;
        s1_g_d       = s1_g_q;
        s1_s_d       = s1_s_q;
        s1_shift_d   = s1_shift_q;
        s1_zero_d    = s1_zero_q;
        s1_sign_d    = s1_sign_q;
        s1_rmode_d   = s1_rmode_q;

        s2_valid_d   = s2_valid_q;
        s2_m_d       = s2_m_q;
        s2_exp_inc_d = s2_exp_inc_q;
        s2_inexact_d = s2_inexact_q;
        s2_zero_d    = s2_zero_q;

        if (s1_ready) begin
            s1_valid_d = Valid_i;
            if (accept) begin
                s1_m_d     = n1_m;
                s1_g_d     = n1_g;
                s1_s_d     = n1_s;
                s1_shift_d = n1_shift;
                s1_zero_d  = n1_zero;
                s1_sign_d  = Sign_i;
                s1_rmode_d = Rmode_i;
            end
        end

        // Output data only changes when S2 is free to load, which keeps the
        // result stable for as long as downstream stalls.
        if (s2_take) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_m_d       = r2_m;
                s2_exp_inc_d = r2_exp_inc;
                s2_inexact_d = r2_inexact;
                s2_zero_d    = s1_zero_q;
            end
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_m_q       <= '0;
            s1_g_q       <= 1'b0;
            s1_s_q       <= 1'b0;
            s1_shift_q   <= 1'b0;
            s1_zero_q    <= 1'b0;
            s1_sign_q    <= 1'b0;
            s1_rmode_q   <= 2'b00;
            s2_valid_q   <= 1'b0;
            s2_m_q       <= '0;
            s2_exp_inc_q <= 2'b00;
            s2_inexact_q <= 1'b0;
            s2_zero_q    <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_m_q       <= s1_m_d;
            s1_g_q       <= s1_g_d;
            s1_s_q       <= s1_s_d;
            s1_shift_q   <= s1_shift_d;
            s1_zero_q    <= s1_zero_d;
            s1_sign_q    <= s1_sign_d;
            s1_rmode_q   <= s1_rmode_d;
            s2_valid_q   <= s2_valid_d;
            s2_m_q       <= s2_m_d;
            s2_exp_inc_q <= s2_exp_inc_d;
            s2_inexact_q <= s2_inexact_d;
            s2_zero_q    <= s2_zero_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign Valid_o   = s2_valid_q;
    assign Data_M_o  = s2_m_q;
    assign Exp_inc_o = s2_exp_inc_q;
    assign Inexact_o = s2_inexact_q;
    assign Zero_o    = s2_zero_q;

endmodule
